opb_regbank_ppc2simulink: RTL and testbench

OPB_REGBANK_PPC2SIMULINK -- requirements
Module: opb_regbank_ppc2simulink

---
 rtl/opb_regbank_pkg.sv | 14 +
 rtl/opb_regbank_word.sv | 37 +++
 rtl/opb_regbank_ppc2simulink.sv | 100 ++++++++++
 tb/tb_opb_regbank_ppc2simulink.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// opb_regbank_pkg: shared FSM type, address-decode constants and parameter checks
package opb_regbank_pkg;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    localparam logic [5:0] COMMIT_IDX = 6'd32;
    localparam int         IDX_MSB    = 24;
    localparam int         IDX_LSB    = 29;

    function automatic bit num_regs_ok(input int n);
        return n >= 1 && n <= 16;
    endfunction

endpackage

// File: rtl/opb_regbank_word.sv
// opb_regbank_word: one 32-bit byte-enabled register with optional shadow/commit stage
module opb_regbank_word #(
    parameter bit DOUBLE_BUF = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic        commit_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] data_o
);

    logic [31:0] shadow_q, shadow_d, data_q;

    always_comb begin
        shadow_d = shadow_q;
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) shadow_d[8*b +: 8] = wdata_i[8*b +: 8];
    end

    // Without double buffering the output tracks the register on the write edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            data_q   <= DOUBLE_BUF ? (commit_i ? shadow_q : data_q) : shadow_d;
        end
    end

    assign rdata_o = shadow_q;
    assign data_o  = data_q;

endmodule

// File: rtl/opb_regbank_ppc2simulink.sv
// opb_regbank_ppc2simulink: OPB slave exposing C_NUM_REGS user registers, optionally
// double-buffered behind a commit register at word index 32
module opb_regbank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01003400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010034FF,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_DOUBLE_BUF = 0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_we
);

    if (!num_regs_ok(C_NUM_REGS)) begin : g_bad_num_regs
        $error("C_NUM_REGS must be in 1..16");
    end
    if (C_BASEADDR[7:0] != 8'h00) begin : g_bad_base
        $error("C_BASEADDR must be 256-byte aligned");
    end

    state_t                  state_q, state_d;
    logic                    hit, wr, commit;
    logic [5:0]              idx;
    logic [31:0]             rdata;
    logic [31:0]             rd [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]   we_vec, user_we_q, user_we_d;
    logic                    unused_seq;

    assign unused_seq = OPB_seqAddr;
    assign hit    = OPB_select && OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
    assign idx    = OPB_ABus[IDX_MSB:IDX_LSB];
    assign wr     = state_q == ACK && hit && !OPB_RNW;
    assign commit = C_DOUBLE_BUF != 0 && wr && idx == COMMIT_IDX;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // ACK always returns to IDLE so a held select starts a fresh transfer
    always_comb begin
        state_d = state_q == IDLE && hit ? ACK : IDLE;
    end

    always_comb begin
        Sl_xferAck = state_q == ACK;
        Sl_DBus    = state_q == ACK && OPB_RNW ? rdata : '0;
        Sl_errAck  = 1'b0;
        Sl_retry   = 1'b0;
        Sl_toutSup = 1'b0;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (idx == 6'(i)) rdata = rd[i];
    end

    always_comb begin
        we_vec = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            we_vec[i] = wr && idx == 6'(i);
        user_we_d = C_DOUBLE_BUF != 0 ? {C_NUM_REGS{commit}} : we_vec;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) user_we_q <= '0;
        else            user_we_q <= user_we_d;
    end

    assign user_we = user_we_q;

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_word
        opb_regbank_word #(.DOUBLE_BUF(C_DOUBLE_BUF != 0)) u_word (
            .clk_i    (OPB_Clk),
            .rst_ni   (OPB_Rst_n),
            .we_i     (we_vec[g]),
            .commit_i (commit),
            .be_i     (OPB_BE),
            .wdata_i  (OPB_DBus),
            .rdata_o  (rd[g]),
            .data_o   (user_data_out[32*g +: 32])
        );
    end

endmodule

// File: tb/tb_opb_regbank_ppc2simulink.sv
// tb_opb_regbank_ppc2simulink: directed checks of a single- and a double-buffered bank
module tb_opb_regbank_ppc2simulink;

    localparam logic [31:0] B = 32'h01003400;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  abus = '0, dbus = '0;
    logic [3:0]   be = '0;
    logic         rnw = 1'b0, sel = 1'b0, seq = 1'b0;
    logic [31:0]  rd0, rd1;
    logic         ack0, ack1;
    logic [1:0]   err, rty, tout;
    logic [127:0] ud0, ud1;
    logic [3:0]   we0, we1;
    int           n_tests = 0, n_fail = 0;
    logic [31:0]  r0, r1;
    int           acks, consec;
    logic         prev;

    always #5 clk = ~clk;

    opb_regbank_ppc2simulink #(.C_DOUBLE_BUF(0)) u_sb (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(rd0), .Sl_xferAck(ack0),
        .Sl_errAck(err[0]), .Sl_retry(rty[0]), .Sl_toutSup(tout[0]),
        .user_data_out(ud0), .user_we(we0)
    );

    opb_regbank_ppc2simulink #(.C_DOUBLE_BUF(1)) u_db (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(rd1), .Sl_xferAck(ack1),
        .Sl_errAck(err[1]), .Sl_retry(rty[1]), .Sl_toutSup(tout[1]),
        .user_data_out(ud1), .user_we(we1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; select stays up through the edge that ends ACK, then drops
    task automatic bus(input logic [31:0] a, input logic r, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] o0, output logic [31:0] o1,
                       output int n);
        o0 = '0; o1 = '0; n = 0;
        @(negedge clk);
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        for (int c = 0; c < 4 && n == 0; c++) begin
            @(negedge clk);
            o0 |= rd0; o1 |= rd1;
            if (ack0) n++;
        end
        if (n != 0) begin
            @(posedge clk); #1;
        end
        sel = 1'b0; rnw = 1'b0;
    endtask

    initial begin
        #1;
        check("rst ack", {ack0, ack1}, 2'b00);
        check("rst dbus", {rd0, rd1}, 64'h0);
        check("rst ud", {ud0, ud1}, 256'h0);
        check("rst tied", {err, rty, tout}, 6'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        bus(B + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF, r0, r1, acks);
        check("wr1 acks", acks, 1);
        check("wr1 we", we0, 4'b0010);
        check("wr1 ud", ud0[63:32], 32'hDEADBEEF);
        check("wr1 db ud", ud1, 128'h0);
        check("wr1 db we", we1, 4'b0000);
        @(posedge clk); #1;
        check("wr1 we clr", we0, 4'b0000);

        bus(B + 32'h4, 1'b1, 4'b1111, 32'h0, r0, r1, acks);
        check("rd1 acks", acks, 1);
        check("rd1 data", r0, 32'hDEADBEEF);
        check("rd1 shadow", r1, 32'hDEADBEEF);

        bus(B, 1'b0, 4'b1111, 32'h11223344, r0, r1, acks);
        bus(B, 1'b0, 4'b0101, 32'hAABBCCDD, r0, r1, acks);
        check("be ud", ud0[31:0], 32'h11BB33DD);
        bus(B, 1'b1, 4'b1111, 32'h0, r0, r1, acks);
        check("be rd", r0, 32'h11BB33DD);
        check("be rd db", r1, 32'h11BB33DD);

        bus(B, 1'b0, 4'b1111, 32'h5, r0, r1, acks);
        bus(B + 32'h4, 1'b0, 4'b1111, 32'h6, r0, r1, acks);
        check("db pre ud", ud1, 128'h0);
        bus(B + 32'h80, 1'b0, 4'b1111, 32'hFFFFFFFF, r0, r1, acks);
        check("commit acks", acks, 1);
        check("commit ud", ud1, {64'h0, 32'h6, 32'h5});
        check("commit we", we1, 4'b1111);
        check("commit sb we", we0, 4'b0000);
        check("commit sb ud", ud0, {64'h0, 32'h6, 32'h5});
        @(posedge clk); #1;
        check("commit we clr", we1, 4'b0000);
        bus(B + 32'h80, 1'b1, 4'b1111, 32'h0, r0, r1, acks);
        check("commit rd", r1, 32'h0);

        bus(32'h01003503, 1'b1, 4'b1111, 32'h0, r0, r1, acks);
        check("oob rd acks", acks, 0);
        check("oob rd dbus", {r0, r1}, 64'h0);
        bus(32'h01003500, 1'b0, 4'b1111, 32'hFFFFFFFF, r0, r1, acks);
        bus(32'h010033FC, 1'b0, 4'b1111, 32'hFFFFFFFF, r0, r1, acks);
        check("oob wr acks", acks, 0);
        check("oob wr ud", ud0, {64'h0, 32'h6, 32'h5});

        bus(B + 32'h40, 1'b1, 4'b1111, 32'h0, r0, r1, acks);
        check("gap rd acks", acks, 1);
        check("gap rd data", r0, 32'h0);
        bus(B + 32'h40, 1'b0, 4'b1111, 32'hFFFFFFFF, r0, r1, acks);
        check("gap wr acks", acks, 1);
        check("gap wr ud", ud0, {64'h0, 32'h6, 32'h5});

        bus(B + 32'h4, 1'b0, 4'b0000, 32'hFFFFFFFF, r0, r1, acks);
        check("be0 acks", acks, 1);
        check("be0 ud", ud0[63:32], 32'h6);

        @(negedge clk);
        abus = B + 32'h8; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFEF00D; sel = 1'b1;
        acks = 0; consec = 0; prev = 1'b0;
        for (int c = 0; c < 8 && acks < 2; c++) begin
            @(negedge clk);
            if (ack0) begin
                acks++;
                if (prev) consec++;
            end
            prev = ack0;
        end
        @(posedge clk); #1;
        sel = 1'b0;
        check("b2b acks", acks, 2);
        check("b2b consec", consec, 0);
        @(negedge clk);
        check("b2b after", ack0, 1'b0);
        check("b2b ud", ud0[95:64], 32'hCAFEF00D);

        @(negedge clk);
        abus = B + 32'hC; rnw = 1'b0; be = 4'b1111; dbus = 32'h12345678; sel = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 4 && !prev; c++) begin
            @(negedge clk);
            prev = ack0;
        end
        check("mid ack seen", prev, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid ack drop", {ack0, ack1}, 2'b00);
        check("mid ud", {ud0, ud1}, 256'h0);
        check("mid we dbus", {we0, we1, rd0, rd1}, 72'h0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid no write", ud0[127:96], 32'h0);
        check("mid no ack", ack0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
